spi_dac_tx: RTL
===============

Name: spi_dac_tx

Overview:
- Serial transmitter that drives a 12-bit SPI DAC (MCP4921-style, 16-bit write frame, LDAC latch) from the pixel-clock domain.
- It is the output-direction counterpart of the serial ADC receiver. It allows processed samples (e.g. the sdft input or a test tone) to be played back out of the badge.
- It accepts one sample per valid/ready handshake, shifts the frame out MSB-first, then pulses LDAC.

Parameters:
- SAMPLE_WIDTH, 12, DAC sample bits; frame data field width.
- CLK_DIV, 4, clk cycles per SCLK half-period (≥1).
- CONFIG_BITS, 4'b0011, frame[15:12]: A/B=0, BUF=0, GA=1 (1x), SHDN=1 (active).

Ports:
- clk  in  1  system clock (pixclk).
- resetn  in  1  asynchronous, active-low reset.
- in_data  in  SAMPLE_WIDTH  sample to send; captured only on handshake.
- in_valid  in  1  sample available.
- in_ready  out  1  block idle and able to accept.
- busy  out  1  frame in progress (= ~in_ready while out of reset).
- dac_clk  out  1  SPI SCLK, idle low.
- dac_cs  out  1  chip select, active low.
- dac_sdi  out  1  serial data, MSB first.
- dac_ldac  out  1  latch DAC output, active low.

Behaviour:
- Reset (resetn low, takes effect immediately; asynchronous): state=IDLE, dac_clk=0, dac_cs=1, dac_sdi=0, dac_ldac=1, busy=0. in_ready=0 while resetn low. From the first clk edge after release: in_ready=1.
- Handshake: accept on any clk edge with in_valid & in_ready.
  - Frame register loads {CONFIG_BITS, in_data} (16 bits).
  - in_ready falls and busy rises on that same edge.
  - in_valid while busy is ignored; in_data is not sampled.
- Divider: counter 0..CLK_DIV-1, reset to 0 on accept and on every state change. It produces tick when count==CLK_DIV-1.
- States:
  - IDLE: outputs at reset values; in_ready=1. Go to SETUP on accept.
  - SETUP (CLK_DIV cycles): dac_cs=0, dac_clk=0, dac_sdi=frame[15]. Go to SHIFT on tick.
  - SHIFT (32*CLK_DIV cycles, 16 bits, bit counter 0..15):
    - Each tick toggles dac_clk.
    - On a high→low toggle, the frame shifts left and dac_sdi shows the next bit. The DAC samples on the rising edge, so data is stable CLK_DIV cycles either side of it.
    - After the 16th falling toggle (dac_clk=0), go to CS_HI.
  - CS_HI (CLK_DIV cycles): dac_cs=1, dac_sdi=0, dac_ldac=1.
  - LDAC (CLK_DIV cycles): dac_ldac=0. On tick: dac_ldac=1, state=IDLE, in_ready=1.
- Timing:
  - dac_cs low for exactly 33*CLK_DIV cycles.
  - in_ready low for exactly 35*CLK_DIV cycles per frame.
  - Exactly 16 rising dac_clk edges per frame.
- Back-to-back: in_valid held high gives a new accept on the first edge with in_ready=1, so the period is 35*CLK_DIV+1 cycles.
- Reset mid-frame: the frame is abandoned at once (dac_cs=1, dac_clk=0, dac_ldac=1); no partial LDAC pulse; the DAC keeps its old value.
- CLK_DIV=1: tick every cycle; same sequence, with no zero-length phases.
- All outputs are registered (glitch-free).

Decomposition:
- Package spi_dac_pkg:
  - State encoding localparams IDLE/SETUP/SHIFT/CS_HI/LDAC.
  - FRAME_W=16.
  - MCP4921 config-bit constants (CFG_BUF, CFG_GA_1X, CFG_SHDN_N).
- Sub-module tick_gen (params DIV): counter with synchronous clear input and a one-cycle tick output. It is reusable by the ADC receiver.

Test Plan:
- Reset: hold resetn low with in_valid=1 → in_ready=0, dac_cs=1, dac_clk=0, dac_ldac=1. After release, in_ready=1 on the first edge; no frame starts until the edge after.
- Single word 12'hABC, CLK_DIV=4 → bits on the 16 rising dac_clk edges = 0011_1010_1011_1100. dac_cs low for 132 cycles, then high 4 cycles, then dac_ldac low 4 cycles; in_ready low for 140 cycles.
- Extremes 12'h000 then 12'hFFF with in_valid held high → frames 16'h3000 and 16'h3FFF. Second accept exactly 141 cycles after the first. in_data changes while busy are not transmitted.
- Pulse resetn low during bit 7 → dac_cs=1, dac_clk=0 asynchronously; no dac_ldac pulse. The next frame (12'h555) transmits 16'h3555 correctly.
- CLK_DIV=1, word 12'h81 → 16 rising edges carrying 16'h3081; dac_cs low 33 cycles; in_ready low 35 cycles.
- Protocol checker throughout: dac_sdi stable ±CLK_DIV around every rising dac_clk, dac_clk=0 whenever dac_cs toggles, dac_ldac low only while dac_cs=1.

Source files
------------

// File: rtl/spi_dac_pkg.sv
// ----------------------------------------------------------------------------
// spi_dac_pkg
// Shared definitions for the MCP4921-style SPI DAC transmitter:
//   - FRAME_W     : width of one SPI write frame (config nibble + 12-bit data)
//   - CFG_*       : individual config bits of frame[15:12]
//   - CFG_DEFAULT : channel A, unbuffered, 1x gain, output active
//   - state_e     : transmitter sequencer states
// ----------------------------------------------------------------------------
package spi_dac_pkg;

  localparam int FRAME_W = 16;

  localparam logic CFG_AB_A   = 1'b0;  // 0 selects DAC channel A
  localparam logic CFG_BUF    = 1'b0;  // Vref input unbuffered
  localparam logic CFG_GA_1X  = 1'b1;  // 1 selects 1x output gain
  localparam logic CFG_SHDN_N = 1'b1;  // 1 keeps the output active

  localparam logic [3:0] CFG_DEFAULT = {CFG_AB_A, CFG_BUF, CFG_GA_1X, CFG_SHDN_N};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    CS_HI = 3'd3,
    LDAC  = 3'd4
  } state_e;

endpackage

// File: rtl/spi_dac_tx_tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen
// Free-running modulo-DIV counter producing a one-cycle tick when the count
// reaches DIV-1. A synchronous clear holds the count at zero, so the first
// tick after clear is released arrives exactly DIV cycles later.
// Ports:
//   clk    : clock
//   resetn : asynchronous active-low reset
//   clr    : synchronous clear (count forced to 0, tick suppressed)
//   tick   : high for one cycle every DIV cycles while clr is low
// ----------------------------------------------------------------------------
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  output logic tick
);

  // Keep at least one counter bit so DIV=1 still elaborates cleanly.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = !clr && (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_dac_tx.sv
// ----------------------------------------------------------------------------
// spi_dac_tx
// Serial transmitter for a 12-bit MCP4921-style SPI DAC. Accepts one sample
// per valid/ready handshake, sends {CONFIG_BITS, sample} MSB-first with SCLK
// idle low (DAC samples on the rising edge), raises CS, then pulses LDAC low
// for one divider period to latch the new value.
// Ports:
//   clk      : system (pixel) clock
//   resetn   : asynchronous active-low reset; abandons any frame at once
//   in_data  : sample to send, captured only on handshake
//   in_valid : sample available
//   in_ready : idle and able to accept (low while in reset)
//   busy     : frame in progress
//   dac_clk  : SPI SCLK, idle low
//   dac_cs   : chip select, active low
//   dac_sdi  : serial data, MSB first
//   dac_ldac : DAC latch strobe, active low
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module spi_dac_tx
  import spi_dac_pkg::*;
#(
  parameter int         SAMPLE_WIDTH = 12,
  parameter int         CLK_DIV      = 4,
  parameter logic [3:0] CONFIG_BITS  = CFG_DEFAULT
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [SAMPLE_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    busy,
  output logic                    dac_clk,
  output logic                    dac_cs,
  output logic                    dac_sdi,
  output logic                    dac_ldac
);

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [3:0]           bitcnt_q, bitcnt_d;
  logic                 sclk_q, sclk_d;
  logic                 cs_q, cs_d;
  logic                 sdi_q, sdi_d;
  logic                 ldac_q, ldac_d;
  logic                 rdy_q, rdy_d;
  logic                 busy_q, busy_d;

  logic                 tick;
  logic                 accept;

  // Holding the divider clear in IDLE restarts it on accept. Every other
  // state change happens on a tick, where the counter wraps to zero anyway,
  // so each phase always starts from a fresh count.
  tick_gen #(
    .DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .clr    (state_q == IDLE),
    .tick   (tick)
  );

  assign accept = in_valid && rdy_q && (state_q == IDLE);

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    bitcnt_d = bitcnt_q;
    sclk_d   = sclk_q;
    cs_d     = cs_q;
    sdi_d    = sdi_q;
    ldac_d   = ldac_q;
    rdy_d    = rdy_q;
    busy_d   = busy_q;

    unique case (state_q)
      IDLE: begin
        rdy_d  = 1'b1;
        busy_d = 1'b0;
        sclk_d = 1'b0;
        cs_d   = 1'b1;
        sdi_d  = 1'b0;
        ldac_d = 1'b1;
        if (accept) begin
          frame_d  = {CONFIG_BITS, in_data};
          bitcnt_d = '0;
          state_d  = SETUP;
          rdy_d    = 1'b0;
          busy_d   = 1'b1;
          cs_d     = 1'b0;
          sdi_d    = CONFIG_BITS[3];
        end
      end

      SETUP: begin
        sdi_d = frame_q[FRAME_W-1];
        if (tick) begin
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (tick) begin
          sclk_d = !sclk_q;
          // Data only moves on the falling edge, a full half-period away
          // from the rising edge the DAC samples on.
          if (sclk_q) begin
            frame_d  = {frame_q[FRAME_W-2:0], 1'b0};
            sdi_d    = frame_q[FRAME_W-2];
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd15) begin
              state_d = CS_HI;
              cs_d    = 1'b1;
              sdi_d   = 1'b0;
            end
          end
        end
      end

      CS_HI: begin
        if (tick) begin
          state_d = LDAC;
          ldac_d  = 1'b0;
        end
      end

      LDAC: begin
        if (tick) begin
          state_d = IDLE;
          ldac_d  = 1'b1;
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        sclk_d  = 1'b0;
        cs_d    = 1'b1;
        sdi_d   = 1'b0;
        ldac_d  = 1'b1;
        rdy_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      bitcnt_q <= '0;
      sclk_q   <= 1'b0;
      cs_q     <= 1'b1;
      sdi_q    <= 1'b0;
      ldac_q   <= 1'b1;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      bitcnt_q <= bitcnt_d;
      sclk_q   <= sclk_d;
      cs_q     <= cs_d;
      sdi_q    <= sdi_d;
      ldac_q   <= ldac_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign in_ready = rdy_q;
  assign busy     = busy_q;
  assign dac_clk  = sclk_q;
  assign dac_cs   = cs_q;
  assign dac_sdi  = sdi_q;
  assign dac_ldac = ldac_q;

endmodule
